video_timing_gen: RTL and testbench

Parametrised raster timing generator for arcade cores. It produces the pixel/line counters the game core addresses video RAM with, plus blank, sync, data-enable and blanked RGB for the video output chain. It generalises the fixed 288x224 generator in the following ways:
- counter geometry is set by parameters;
- it runs on a clock enable rather than a derived clock;
- sync positions can be moved at run time for screen centring, and changes take effect on frame boundaries;
- it emits line and frame strobes.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/sync_pulse.sv | 36 +++
 rtl/video_timing_gen.sv | 124 ++++++++++++
 tb/tb_video_timing_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared geometry defaults and helpers for the raster timing generator.
package video_timing_pkg;

  localparam int DIGDUG_CW       = 9;
  localparam int DIGDUG_RGB_W    = 12;
  localparam int DIGDUG_H_ACTIVE = 288;
  localparam int DIGDUG_H_SYNC   = 312;
  localparam int DIGDUG_H_SYNC_W = 31;
  localparam int DIGDUG_H_JUMP   = 342;
  localparam int DIGDUG_H_RESUME = 471;
  localparam int DIGDUG_V_ACTIVE = 224;
  localparam int DIGDUG_V_SYNC   = 227;
  localparam int DIGDUG_V_SYNC_W = 7;
  localparam int DIGDUG_V_JUMP   = 233;
  localparam int DIGDUG_V_RESUME = 483;

  // int is wider than CW+2, so the clamped result matches CW+2-bit signed arithmetic.
  function automatic int sat_add(input int base, input int off, input int lo, input int hi);
    int sum;
    sum = base + off;
    if (sum < lo) return lo;
    if (sum > hi) return hi;
    return sum;
  endfunction

endpackage

// File: rtl/sync_pulse.sv
// Retriggerable fixed-length pulse: loads len_i on start, counts down on each advance.
module sync_pulse #(
  parameter int unsigned W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         advance_i,
  input  logic         start_i,
  input  logic [W-1:0] len_i,
  output logic         level_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) begin
      if (start_i) begin
        cnt_d = len_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign level_o = (cnt_q != '0);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: stage-0 counters and strobes, stage-1 blank/sync/rgb.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW       = DIGDUG_CW,
  parameter int RGB_W    = DIGDUG_RGB_W,
  parameter int H_ACTIVE = DIGDUG_H_ACTIVE,
  parameter int H_SYNC   = DIGDUG_H_SYNC,
  parameter int H_SYNC_W = DIGDUG_H_SYNC_W,
  parameter int H_JUMP   = DIGDUG_H_JUMP,
  parameter int H_RESUME = DIGDUG_H_RESUME,
  parameter int V_ACTIVE = DIGDUG_V_ACTIVE,
  parameter int V_SYNC   = DIGDUG_V_SYNC,
  parameter int V_SYNC_W = DIGDUG_V_SYNC_W,
  parameter int V_JUMP   = DIGDUG_V_JUMP,
  parameter int V_RESUME = DIGDUG_V_RESUME
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic signed [3:0] hoff,
  input  logic signed [3:0] voff,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic [CW-1:0]     hpos,
  output logic [CW-1:0]     vpos,
  output logic              line_start,
  output logic              frame_start,
  output logic              hblank,
  output logic              vblank,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam logic [CW-1:0] HActive = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HJump   = CW'(H_JUMP);
  localparam logic [CW-1:0] HResume = CW'(H_RESUME);
  localparam logic [CW-1:0] VActive = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VJump   = CW'(V_JUMP);
  localparam logic [CW-1:0] VResume = CW'(V_RESUME);

  logic [CW-1:0]     hpos_q, hpos_d, vpos_q, vpos_d;
  logic signed [3:0] hoff_q, voff_q;
  logic              hblank_q, vblank_q, de_q;
  logic [RGB_W-1:0]  rgb_q;
  logic [CW-1:0]     hs_start, vs_start;
  logic              line_wrap, frame_wrap, hblank_c, vblank_c;

  always_comb begin
    hpos_d = (hpos_q == HJump) ? HResume : hpos_q + CW'(1);
    vpos_d = vpos_q;
    if (hpos_d == '0) begin
      vpos_d = (vpos_q == VJump) ? VResume : vpos_q + CW'(1);
    end
  end

  assign line_wrap   = (hpos_d == '0);
  assign frame_wrap  = line_wrap && (vpos_d == '0);
  assign line_start  = ce_pix && !reset && line_wrap;
  assign frame_start = ce_pix && !reset && frame_wrap;

  assign hs_start = CW'(sat_add(H_SYNC, int'(hoff_q), H_ACTIVE, H_JUMP));
  assign vs_start = CW'(sat_add(V_SYNC, int'(voff_q), V_ACTIVE, V_JUMP));

  assign hblank_c = (hpos_q >= HActive);
  assign vblank_c = (vpos_q >= VActive);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hpos_q   <= '0;
      vpos_q   <= '0;
      hoff_q   <= hoff;
      voff_q   <= voff;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else if (ce_pix) begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      // Offsets only move on frame boundaries so a frame never has two sync positions.
      if (frame_wrap) begin
        hoff_q <= hoff;
        voff_q <= voff;
      end
      hblank_q <= hblank_c;
      vblank_q <= vblank_c;
      de_q     <= !hblank_c && !vblank_c;
      rgb_q    <= (!hblank_c && !vblank_c) ? rgb_in : '0;
    end
  end

  sync_pulse #(
    .W(CW)
  ) u_hsync (
    .clk_i    (clk_sys),
    .rst_i    (reset),
    .advance_i(ce_pix),
    .start_i  (hpos_q == hs_start),
    .len_i    (CW'(H_SYNC_W)),
    .level_o  (hsync)
  );

  // Vertical pulse starts on the line start that enters vs_start.
  sync_pulse #(
    .W(CW)
  ) u_vsync (
    .clk_i    (clk_sys),
    .rst_i    (reset),
    .advance_i(line_start),
    .start_i  (vpos_d == vs_start),
    .len_i    (CW'(V_SYNC_W)),
    .level_o  (vsync)
  );

  assign hpos    = hpos_q;
  assign vpos    = vpos_q;
  assign hblank  = hblank_q;
  assign vblank  = vblank_q;
  assign de      = de_q;
  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: small-geometry instance checked every clock against a line/frame model,
// default-geometry instance checked with hand-written measurements.
module tb_video_timing_gen;

  localparam int SCW = 6, SHA = 20, SHS = 24, SHSW = 5, SHJ = 34, SHR = 58;
  localparam int SVA = 12, SVS = 14, SVSW = 3, SVJ = 20, SVR = 60;
  localparam int SFRAME = 41 * 25;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ce_pix = 1'b0;
  logic signed [3:0] hoff = 4'sd0;
  logic signed [3:0] voff = 4'sd0;
  logic [11:0]       rgb_in = 12'h000;

  logic [SCW-1:0] s_hpos, s_vpos;
  logic           s_ls, s_fs, s_hb, s_vb, s_de, s_hs, s_vs;
  logic [11:0]    s_rgb;
  logic [8:0]     d_hpos, d_vpos;
  logic           d_ls, d_fs, d_hb, d_vb, d_de, d_hs, d_vs;
  logic [11:0]    d_rgb;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CW(SCW), .RGB_W(12), .H_ACTIVE(SHA), .H_SYNC(SHS), .H_SYNC_W(SHSW), .H_JUMP(SHJ),
    .H_RESUME(SHR), .V_ACTIVE(SVA), .V_SYNC(SVS), .V_SYNC_W(SVSW), .V_JUMP(SVJ),
    .V_RESUME(SVR)
  ) u_small (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hoff(hoff), .voff(voff),
    .rgb_in(rgb_in), .hpos(s_hpos), .vpos(s_vpos), .line_start(s_ls), .frame_start(s_fs),
    .hblank(s_hb), .vblank(s_vb), .de(s_de), .hsync(s_hs), .vsync(s_vs), .rgb_out(s_rgb)
  );

  video_timing_gen u_dflt (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hoff(hoff), .voff(voff),
    .rgb_in(rgb_in), .hpos(d_hpos), .vpos(d_vpos), .line_start(d_ls), .frame_start(d_fs),
    .hblank(d_hb), .vblank(d_vb), .de(d_de), .hsync(d_hs), .vsync(d_vs), .rgb_out(d_rgb)
  );

  int total = 0;
  int bad = 0;

  // Reference model: position is an index into the list of hpos/vpos values of one line/frame.
  int hl[$];
  int vl[$];
  int hix, vix, m_ho, m_vo, ce_n, ln_n, last_h, last_v;
  bit m_hb, m_vb, m_de;
  logic [11:0] m_rgb;

  int prev_hpos;
  bit prev_hs, prev_vs, d_prev_hs, saw_fs;
  int ls_cnt, fs_cnt, de_cnt, hb_cnt;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic tick(input bit rst, input bit ce, input logic [11:0] rgb, input int ho,
                      input int vo);
    int hp, vp;
    bit els, efs;
    @(negedge clk);
    reset  = rst;
    ce_pix = ce;
    rgb_in = rgb;
    hoff   = 4'(ho);
    voff   = 4'(vo);
    #1;
    els = ce && !rst && (hix == hl.size() - 1);
    efs = els && (vix == vl.size() - 1);
    check("line_start", int'(s_ls), int'(els));
    check("frame_start", int'(s_fs), int'(efs));
    prev_hpos = int'(s_hpos);
    prev_hs   = s_hs;
    prev_vs   = s_vs;
    d_prev_hs = d_hs;
    saw_fs    = s_fs;
    if (s_ls) ls_cnt++;
    if (s_fs) fs_cnt++;
    @(posedge clk);
    if (rst) begin
      hix = 0; vix = 0; m_ho = ho; m_vo = vo;
      m_hb = 1'b1; m_vb = 1'b1; m_de = 1'b0; m_rgb = '0;
      ce_n = 0; ln_n = 0; last_h = -1000; last_v = -1000;
    end else if (ce) begin
      hp = hl[hix];
      vp = vl[vix];
      m_hb  = (hp >= SHA);
      m_vb  = (vp >= SVA);
      m_de  = !m_hb && !m_vb;
      m_rgb = m_de ? rgb : 12'h000;
      ce_n++;
      if (hp == clamp(SHS + m_ho, SHA, SHJ)) last_h = ce_n;
      hix = (hix + 1) % hl.size();
      if (hix == 0) begin
        ln_n++;
        vix = (vix + 1) % vl.size();
        if (vl[vix] == clamp(SVS + m_vo, SVA, SVJ)) last_v = ln_n;
        if (vix == 0) begin
          m_ho = ho;
          m_vo = vo;
        end
      end
    end
    #1;
    check("hpos", int'(s_hpos), hl[hix]);
    check("vpos", int'(s_vpos), vl[vix]);
    check("hblank", int'(s_hb), int'(m_hb));
    check("vblank", int'(s_vb), int'(m_vb));
    check("de", int'(s_de), int'(m_de));
    check("rgb_out", int'(s_rgb), int'(m_rgb));
    check("hsync", int'(s_hs), int'(ce_n - last_h < SHSW));
    check("vsync", int'(s_vs), int'(ln_n - last_v < SVSW));
    if (s_de) de_cnt++;
    if (s_hb) hb_cnt++;
  endtask

  typedef struct {
    int ho;
    int vo;
    int exp_hs;
    int exp_vs;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int cur_ho, cur_vo, cnt, since0, hbc, dec, rises, hs_w, prev_exp, hs_pos, vs_pos;

    for (int p = 0; p <= SHJ; p++) hl.push_back(p);
    for (int p = SHR; p < (1 << SCW); p++) hl.push_back(p);
    for (int p = 0; p <= SVJ; p++) vl.push_back(p);
    for (int p = SVR; p < (1 << SCW); p++) vl.push_back(p);

    tbl[0] = '{0, 0, 24, 14};
    tbl[1] = '{7, 0, 31, 14};
    tbl[2] = '{-8, 0, 20, 14};
    tbl[3] = '{0, 7, 24, 20};
    tbl[4] = '{0, -8, 24, 12};
    tbl[5] = '{-3, 2, 21, 16};

    // Reset state of the default-geometry instance
    repeat (2) tick(1'b1, 1'b1, 12'h000, 0, 0);
    check("d_rst_hpos", int'(d_hpos), 0);
    check("d_rst_vpos", int'(d_vpos), 0);
    check("d_rst_hblank", int'(d_hb), 1);
    check("d_rst_vblank", int'(d_vb), 1);
    check("d_rst_de", int'(d_de), 0);
    check("d_rst_hsync", int'(d_hs), 0);
    check("d_rst_vsync", int'(d_vs), 0);
    check("d_rst_rgb", int'(d_rgb), 0);
    tick(1'b0, 1'b1, 12'h123, 0, 0);
    check("d_first_ce_hpos", int'(d_hpos), 1);

    // Default line length, blanking, and hsync placement/width
    since0 = 1; hbc = 0; dec = 0; rises = 0; hs_w = 0;
    for (int c = 1; c <= 2 * 384 + 4; c++) begin
      tick(1'b0, 1'b1, 12'($urandom), 0, 0);
      since0++;
      if (int'(d_hpos) == 0) begin
        check("d_line_len", since0, 384);
        since0 = 0;
      end
      if (c <= 384) begin
        if (d_hb) hbc++;
        if (d_de) dec++;
      end
      if (d_hs && !d_prev_hs) begin
        check("d_hs_rise_hpos", int'(d_hpos), SHS * 0 + 313);
        rises++;
        hs_w = 0;
      end
      if (d_hs) hs_w++;
      if (!d_hs && d_prev_hs) check("d_hs_width", hs_w, 31);
    end
    check("d_hblank_per_line", hbc, 96);
    check("d_de_per_line", dec, 288);
    check("d_hs_rises", rises, 2);

    // Reset mid-line with ce low
    cnt = 0;
    while (int'(d_hpos) != 150 && cnt < 500) begin
      tick(1'b0, 1'b1, 12'h000, 0, 0);
      cnt++;
    end
    check("d_reach_150", int'(d_hpos), 150);
    tick(1'b1, 1'b0, 12'h000, 0, 0);
    check("d_midrst_hpos", int'(d_hpos), 0);
    check("d_midrst_vpos", int'(d_vpos), 0);
    check("d_midrst_hblank", int'(d_hb), 1);
    check("d_midrst_hsync", int'(d_hs), 0);
    tick(1'b0, 1'b1, 12'h000, 0, 0);
    check("d_restart_hpos", int'(d_hpos), 1);

    // Offset table: change at vpos 5, old offset this frame, new one from the next
    cur_ho = 0; cur_vo = 0; prev_exp = 24;
    for (int r = 0; r < 6; r++) begin
      cnt = 0;
      while (int'(s_vpos) != 5 && cnt < 2000) begin
        tick(1'b0, 1'b1, 12'($urandom), cur_ho, cur_vo);
        cnt++;
      end
      check("reach_vpos5", int'(s_vpos), 5);
      cur_ho = tbl[r].ho;
      cur_vo = tbl[r].vo;
      hs_pos = -1;
      for (int c = 0; c < 100 && hs_pos < 0; c++) begin
        tick(1'b0, 1'b1, 12'($urandom), cur_ho, cur_vo);
        if (s_hs && !prev_hs) hs_pos = prev_hpos;
      end
      check("hs_same_frame", hs_pos, prev_exp);
      cnt = 0;
      saw_fs = 1'b0;
      while (!saw_fs && cnt < 1100) begin
        tick(1'b0, 1'b1, 12'($urandom), cur_ho, cur_vo);
        cnt++;
      end
      check("wait_frame_start", int'(saw_fs), 1);
      hs_pos = -1; vs_pos = -1;
      for (int c = 0; c < SFRAME; c++) begin
        tick(1'b0, 1'b1, 12'($urandom), cur_ho, cur_vo);
        if (s_hs && !prev_hs && hs_pos < 0) hs_pos = prev_hpos;
        if (s_vs && !prev_vs && vs_pos < 0) vs_pos = int'(s_vpos);
      end
      check("hs_start_new", hs_pos, tbl[r].exp_hs);
      check("vs_start_new", vs_pos, tbl[r].exp_vs);
      prev_exp = tbl[r].exp_hs;
    end

    // Free-run three frames of the small geometry
    cnt = 0;
    saw_fs = 1'b0;
    while (!saw_fs && cnt < 1100) begin
      tick(1'b0, 1'b1, 12'($urandom), 0, 0);
      cnt++;
    end
    check("wait_frame_start2", int'(saw_fs), 1);
    for (int f = 0; f < 3; f++) begin
      ls_cnt = 0; fs_cnt = 0; de_cnt = 0; hb_cnt = 0;
      for (int c = 0; c < SFRAME; c++) tick(1'b0, 1'b1, 12'($urandom), 0, 0);
      check("lines_per_frame", ls_cnt, 25);
      check("frames_per_frame", fs_cnt, 1);
      check("de_per_frame", de_cnt, 20 * 12);
      check("hblank_per_frame", hb_cnt, 21 * 25);
    end

    // ce every 4th clock with a constant pixel; blanked output must be zero
    for (int c = 0; c < 600; c++) begin
      tick(1'b0, (c % 4) == 0, 12'hABC, 0, 0);
      if (s_hb || s_vb) check("rgb_blank", int'(s_rgb), 0);
    end

    // Random ce, pixels, offsets and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        cur_ho = int'($urandom_range(0, 15)) - 8;
        cur_vo = int'($urandom_range(0, 15)) - 8;
      end
      tick($urandom_range(0, 699) == 0, $urandom_range(0, 2) != 0, 12'($urandom),
           cur_ho, cur_vo);
    end

    // Reset while vsync is active
    cnt = 0;
    while (!s_vs && cnt < 3000) begin
      tick(1'b0, 1'b1, 12'($urandom), cur_ho, cur_vo);
      cnt++;
    end
    check("reach_vsync", int'(s_vs), 1);
    tick(1'b1, 1'b0, 12'h000, 0, 0);
    check("vs_rst_vsync", int'(s_vs), 0);
    check("vs_rst_hsync", int'(s_hs), 0);
    check("vs_rst_hpos", int'(s_hpos), 0);
    check("vs_rst_vpos", int'(s_vpos), 0);
    check("vs_rst_hblank", int'(s_hb), 1);
    tick(1'b0, 1'b1, 12'h000, 0, 0);
    check("vs_restart_hpos", int'(s_hpos), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
